// File: rtl/line_window_controller_pkg.sv
// Shared constants, read-state encoding and index helpers for the line window controller.
// Pure compile-time content: no latency, no flow control.
package line_ctrl_pkg;

    localparam int K_MAX = 7;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } rd_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Base bit of pixel (row, col) in a packed k x k window: row 0 / col 0 sit in the MSBs.
    function automatic int win_base(input int row, input int col, input int k, input int pix_w);
        return (k * k - 1 - (row * k + col)) * pix_w;
    endfunction

endpackage

// File: rtl/line_window_controller_if.sv
// Pixel-in / window-out handshake bundle between source, controller and filter datapath.
// master drives pixels and out_ready; slave (the controller) drives in_ready and the window.
interface line_window_controller_if #(
    parameter int PIX_W = 8,
    parameter int K     = 3
);
    localparam int CNT_W = line_ctrl_pkg::clog2(K + 2);

    logic [PIX_W-1:0]       in_pixel;
    logic                   in_valid;
    logic                   in_ready;
    logic [K*K*PIX_W-1:0]   out_window;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_eol;
    logic [CNT_W-1:0]       lines_buffered;

    modport master (
        output in_pixel, in_valid, out_ready,
        input  in_ready, out_window, out_valid, out_eol, lines_buffered
    );

    modport slave (
        input  in_pixel, in_valid, out_ready,
        output in_ready, out_window, out_valid, out_eol, lines_buffered
    );

endinterface

// File: rtl/line_window_controller_line_buffer.sv
// One image line of pixels: single write port, K-tap combinational read (lowest column in MSBs).
// Write lands on the clock edge; reads are zero-latency; no flow control of its own.
module line_buffer_param
    import line_ctrl_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int IMG_W = 512,
    parameter int K     = 3
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [clog2(IMG_W)-1:0]    waddr,
    input  logic [PIX_W-1:0]           wdata,
    input  logic [clog2(IMG_W)-1:0]    raddr,
    output logic [K*PIX_W-1:0]         rdata
);
    localparam int AW = clog2(IMG_W);

    logic [PIX_W-1:0] mem [IMG_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // raddr never exceeds IMG_W-K, so every tap stays inside the line.
    for (genvar c = 0; c < K; c++) begin : g_tap
        assign rdata[(K-1-c)*PIX_W +: PIX_W] = mem[raddr + AW'(c)];
    end

endmodule

// File: rtl/line_window_controller.sv
// Buffers a raster stream in K+1 circular lines and emits one KxK window per output handshake.
// First window 1 cycle after the K-th line completes; in_ready drops when all lines are held.
module line_window_controller
    import line_ctrl_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int IMG_W = 512,
    parameter int K     = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    line_window_controller_if.slave  bus
);
    localparam int NUM_LB = K + 1;
    localparam int COL_W  = clog2(IMG_W);
    localparam int LB_W   = clog2(NUM_LB);
    localparam int CNT_W  = clog2(NUM_LB + 1);
    localparam int ROW_W  = K * PIX_W;
    localparam int WIN_W  = K * ROW_W;

    localparam logic [COL_W-1:0] WR_LAST  = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] RD_LAST  = COL_W'(IMG_W - K);
    localparam logic [LB_W-1:0]  LB_LAST  = LB_W'(NUM_LB - 1);
    localparam logic [LB_W:0]    LB_NUM   = (LB_W + 1)'(NUM_LB);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_LB);
    localparam logic [CNT_W-1:0] CNT_K    = CNT_W'(K);

    rd_state_t          state;
    rd_state_t          state_nxt;

    logic [COL_W-1:0]   wr_col;
    logic [COL_W-1:0]   rd_col;
    logic [LB_W-1:0]    wr_lb;
    logic [LB_W-1:0]    rd_lb;
    logic [CNT_W-1:0]   lines_buffered;
    logic [CNT_W-1:0]   lb_nxt;

    logic [WIN_W-1:0]   out_window_q;
    logic               out_valid_q;
    logic               out_eol_q;

    logic               in_ready_i;
    logic               in_xfer;
    logic               wr_wrap;
    logic               rd_wrap;
    logic               load;

    logic [ROW_W-1:0]   taps [NUM_LB];
    logic [WIN_W-1:0]   window_nxt;

    function automatic logic [LB_W-1:0] lb_inc(input logic [LB_W-1:0] v);
        return (v == LB_LAST) ? '0 : v + 1'b1;
    endfunction

    assign in_ready_i = (lines_buffered < CNT_FULL);

    for (genvar b = 0; b < NUM_LB; b++) begin : g_lb
        line_buffer_param #(
            .PIX_W (PIX_W),
            .IMG_W (IMG_W),
            .K     (K)
        ) u_lb (
            .clk   (clk),
            .we    (in_xfer && (wr_lb == LB_W'(b))),
            .waddr (wr_col),
            .wdata (bus.in_pixel),
            .raddr (rd_col),
            .rdata (taps[b])
        );
    end

    // Row r of the window comes from buffer (rd_lb + r) mod NUM_LB.
    for (genvar r = 0; r < K; r++) begin : g_row
        logic [LB_W:0]   sum;
        logic [LB_W-1:0] sel;
        assign sum = {1'b0, rd_lb} + (LB_W + 1)'(r);
        assign sel = (sum >= LB_NUM) ? LB_W'(sum - LB_NUM) : sum[LB_W-1:0];
        for (genvar c = 0; c < K; c++) begin : g_col
            assign window_nxt[win_base(r, c, K, PIX_W) +: PIX_W] = taps[sel][(K-1-c)*PIX_W +: PIX_W];
        end
    end

    always_comb begin
        in_xfer   = bus.in_valid && in_ready_i;
        wr_wrap   = in_xfer && (wr_col == WR_LAST);
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                // Start loading in the same cycle the K-th line is seen complete.
                if (lines_buffered >= CNT_K) begin
                    state_nxt = ST_STREAM;
                    load      = !out_valid_q || bus.out_ready;
                end
            end
            ST_STREAM: begin
                load = !out_valid_q || bus.out_ready;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        rd_wrap = load && (rd_col == RD_LAST);
        lb_nxt  = lines_buffered + CNT_W'(wr_wrap) - CNT_W'(rd_wrap);
        if (rd_wrap && (lb_nxt < CNT_K)) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else if (clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_col         <= '0;
            wr_lb          <= '0;
            rd_col         <= '0;
            rd_lb          <= '0;
            lines_buffered <= '0;
            out_window_q   <= '0;
            out_valid_q    <= 1'b0;
            out_eol_q      <= 1'b0;
        end else if (clear) begin
            wr_col         <= '0;
            wr_lb          <= '0;
            rd_col         <= '0;
            rd_lb          <= '0;
            lines_buffered <= '0;
            out_window_q   <= '0;
            out_valid_q    <= 1'b0;
            out_eol_q      <= 1'b0;
        end else begin
            if (in_xfer) begin
                wr_col <= wr_wrap ? '0 : wr_col + 1'b1;
                if (wr_wrap) begin
                    wr_lb <= lb_inc(wr_lb);
                end
            end
            lines_buffered <= lb_nxt;
            if (load) begin
                out_window_q <= window_nxt;
                out_valid_q  <= 1'b1;
                out_eol_q    <= (rd_col == RD_LAST);
                rd_col       <= rd_wrap ? '0 : rd_col + 1'b1;
                if (rd_wrap) begin
                    rd_lb <= lb_inc(rd_lb);
                end
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
                out_eol_q   <= 1'b0;
            end
        end
    end

    assign bus.in_ready       = in_ready_i;
    assign bus.out_window     = out_window_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_eol        = out_eol_q;
    assign bus.lines_buffered = lines_buffered;

endmodule

// File: tb/tb_line_window_controller.sv
// Directed bench for line_window_controller at IMG_W=8, K=3, PIX_W=8; pixel value = running index.
module tb_line_window_controller;

    logic clk;
    logic reset;
    logic clear;
    int   n_tests;
    int   n_fail;

    line_window_controller_if #(.PIX_W(8), .K(3)) bus ();

    line_window_controller #(
        .PIX_W (8),
        .IMG_W (8),
        .K     (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Window whose row 0 is line l0 and whose first column is c0.
    function automatic logic [71:0] exp_win(input int l0, input int c0);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w[(8 - (r * 3 + c)) * 8 +: 8] = 8'((l0 + r) * 8 + c0 + c);
            end
        end
        return w;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, bus.out_valid, 1'b0);
        check({tag, "_out_eol"}, bus.out_eol, 1'b0);
        check({tag, "_out_window"}, bus.out_window, 72'h0);
        check({tag, "_lines_buffered"}, bus.lines_buffered, 3'd0);
        check({tag, "_in_ready"}, bus.in_ready, 1'b1);
    endtask

    task automatic run_frame1(input string tag);
        logic early;
        early = 1'b0;
        bus.out_ready = 1'b1;
        for (int p = 0; p < 24; p++) begin
            bus.in_valid = 1'b1;
            bus.in_pixel = 8'(p);
            tick();
            if (bus.out_valid) early = 1'b1;
        end
        bus.in_valid = 1'b0;
        check({tag, "_no_early_valid"}, early, 1'b0);
        check({tag, "_lb_after_line3"}, bus.lines_buffered, 3'd3);
        tick();
        check({tag, "_first_valid"}, bus.out_valid, 1'b1);
        check({tag, "_first_window"}, bus.out_window, exp_win(0, 0));
        check({tag, "_first_eol"}, bus.out_eol, 1'b0);
        for (int c = 1; c < 6; c++) begin
            tick();
            check({tag, "_win_col"}, bus.out_window, exp_win(0, c));
            check({tag, "_eol_col"}, bus.out_eol, (c == 5));
        end
        tick();
        check({tag, "_valid_drop"}, bus.out_valid, 1'b0);
        check({tag, "_lb_after_release"}, bus.lines_buffered, 3'd2);
        check({tag, "_in_ready_end"}, bus.in_ready, 1'b1);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset         = 1'b1;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pixel  = '0;
        bus.out_ready = 1'b0;

        #1 reset = 1'b0;
        tick();
        tick();
        check_reset_state("reset");
        reset = 1'b1;
        tick();

        // Scenario 1: streaming frame with consumer always ready.
        run_frame1("s1");

        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("s2_clear_lb", bus.lines_buffered, 3'd0);

        // Scenario 2: consumer stalled, buffers fill.
        bus.out_ready = 1'b0;
        for (int p = 0; p < 32; p++) begin
            bus.in_valid = 1'b1;
            bus.in_pixel = 8'(p);
            tick();
        end
        check("s2_in_ready_full", bus.in_ready, 1'b0);
        check("s2_lb_full", bus.lines_buffered, 3'd4);
        check("s2_valid_held", bus.out_valid, 1'b1);
        check("s2_window_held", bus.out_window, exp_win(0, 0));
        bus.in_pixel = 8'd32;
        tick();
        tick();
        tick();
        check("s2_pixel32_held_off", bus.lines_buffered, 3'd4);
        check("s2_in_ready_still_low", bus.in_ready, 1'b0);
        check("s2_window_stable", bus.out_window, exp_win(0, 0));

        // Scenario 3: drain one line while full.
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 1; c < 5; c++) begin
            tick();
            check("s3_win_col", bus.out_window, exp_win(0, c));
        end
        check("s3_in_ready_before_release", bus.in_ready, 1'b0);
        tick();
        check("s3_eol", bus.out_eol, 1'b1);
        check("s3_win_col5", bus.out_window, exp_win(0, 5));
        check("s3_lb_after_release", bus.lines_buffered, 3'd3);
        check("s3_in_ready_after_release", bus.in_ready, 1'b1);
        tick();
        bus.out_ready = 1'b0;
        check("s3_next_line_window", bus.out_window, exp_win(1, 0));
        check("s3_next_eol", bus.out_eol, 1'b0);

        // Scenario 4: line 4 completes in the same cycle line 1 is released.
        for (int p = 32; p < 35; p++) begin
            bus.in_valid = 1'b1;
            bus.in_pixel = 8'(p);
            tick();
        end
        bus.out_ready = 1'b1;
        for (int k = 1; k < 6; k++) begin
            bus.in_pixel = 8'(34 + k);
            tick();
            check("s4_win_col", bus.out_window, exp_win(1, k));
        end
        bus.in_valid = 1'b0;
        check("s4_lb_unchanged", bus.lines_buffered, 3'd3);
        check("s4_eol", bus.out_eol, 1'b1);
        tick();
        check("s4_still_streaming", bus.out_valid, 1'b1);
        check("s4_window_line2", bus.out_window, exp_win(2, 0));
        check("s4_lb_after", bus.lines_buffered, 3'd3);

        // Scenario 5: synchronous clear mid-stream, with a pixel offered in the same cycle.
        bus.out_ready = 1'b0;
        for (int p = 40; p < 45; p++) begin
            bus.in_valid = 1'b1;
            bus.in_pixel = 8'(p);
            tick();
        end
        check("s5_valid_before_clear", bus.out_valid, 1'b1);
        clear        = 1'b1;
        bus.in_pixel = 8'd45;
        tick();
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        check_reset_state("s5_clear");
        tick();
        run_frame1("s5_refill");

        // Scenario 6: asynchronous reset between clock edges.
        bus.out_ready = 1'b0;
        for (int p = 0; p < 10; p++) begin
            bus.in_valid = 1'b1;
            bus.in_pixel = 8'(p);
            tick();
        end
        check("s6_valid_before_reset", bus.out_valid, 1'b1);
        #2;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check_reset_state("s6_async");
        @(posedge clk);
        #3 reset = 1'b1;
        tick();
        run_frame1("s6_restart");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
